// File: rtl/ascii_link_pkg.sv
// Shared definitions for the 7-bit ASCII serial link (transmitter and receiver).
//   CHAR_W     : bits per character, also the frame length in clocks
//   IDLE_CHAR  : filler character sent when nothing is queued
//   FIFO_DEPTH : default transmit character buffer depth
//   state_t    : serializer FSM states
package ascii_link_pkg;

  localparam int unsigned CHAR_W     = 7;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [CHAR_W-1:0] IDLE_CHAR = 7'h00;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/char_fifo.sv
// Character FIFO: DEPTH x WIDTH circular buffer with occupancy count.
//   clk, rst  : clock, asynchronous active-low reset
//   push/wdata: write request and data (ignored when full)
//   pop       : read request (ignored when empty)
//   rdata_c   : current head entry
//   count     : registered occupancy, 0..DEPTH
//   full_c    : count == DEPTH
//   empty_c   : count == 0
module char_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 7,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic [CNT_W-1:0] count,
  output logic             full_c,
  output logic             empty_c
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;
  assign rdata_c = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ascii_serializer.sv
// Transmit side of the 7-bit ASCII serial link. Buffers characters and
// shifts each one out MSB-first, one bit per clock, frames back-to-back;
// IDLE filler frames keep framing alive when nothing is queued.
//   clk, rst : clock, asynchronous active-low reset
//   in_ascii : character to send
//   in_valid : in_ascii valid
//   in_ready : buffer can accept (combinational from occupancy)
//   out_bin  : serial data bit
//   out_sof  : high while out_bin carries the first (MSB) bit of a frame
//   out_en   : high once streaming has started after reset
//   out_fill : high for the whole of an IDLE filler frame
module ascii_serializer
  import ascii_link_pkg::*;
#(
  parameter int unsigned       DEPTH = FIFO_DEPTH,
  parameter logic [CHAR_W-1:0] IDLE  = IDLE_CHAR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHAR_W-1:0] in_ascii,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bin,
  output logic              out_sof,
  output logic              out_en,
  output logic              out_fill
);

  localparam int unsigned BIT_W = $clog2(CHAR_W);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CHAR_W-1:0] shreg;

  logic              boundary_c;
  logic              push_c;
  logic [CHAR_W-1:0] head_c;
  logic [CHAR_W-1:0] load_c;
  logic [BIT_W-1:0]  bit_idx_c;
  logic [CNT_W-1:0]  count;
  logic              full_c;
  logic              empty_c;

  assign boundary_c = (bit_cnt == '0);
  assign push_c     = in_valid && (state == S_RUN) && !full_c;
  assign in_ready   = (count < CNT_W'(DEPTH));
  // No bypass: an empty buffer at a boundary always yields a filler frame.
  assign load_c     = empty_c ? IDLE : head_c;
  assign bit_idx_c  = BIT_W'(CHAR_W - 1) - bit_cnt;

  char_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CHAR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .wdata   (in_ascii),
    .pop     (boundary_c),
    .rdata_c (head_c),
    .count   (count),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // FSM, frame counter and shifter with registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_WAIT;
      bit_cnt  <= '0;
      shreg    <= '0;
      out_bin  <= 1'b0;
      out_sof  <= 1'b0;
      out_en   <= 1'b0;
      out_fill <= 1'b0;
    end else begin
      case (state)
        S_WAIT:  state <= S_RUN;
        S_RUN:   state <= S_RUN;
        default: state <= S_WAIT;
      endcase
      if (boundary_c) begin
        shreg    <= load_c;
        out_bin  <= load_c[CHAR_W-1];
        out_sof  <= 1'b1;
        out_en   <= 1'b1;
        out_fill <= empty_c;
        bit_cnt  <= BIT_W'(1);
      end else begin
        out_bin <= shreg[bit_idx_c];
        out_sof <= 1'b0;
        bit_cnt <= (bit_cnt == BIT_W'(CHAR_W - 1)) ? '0 : bit_cnt + BIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ascii_serializer.sv
// Self-checking bench for ascii_serializer: a behavioural queue model predicts
// each frame at its boundary edge; a serial monitor reassembles frames and
// compares them against the predicted frame queue.
module tb_ascii_serializer;
  import ascii_link_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] in_ascii = 7'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       out_bin;
  logic       out_sof;
  logic       out_en;
  logic       out_fill;

  ascii_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .in_ascii (in_ascii),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_bin  (out_bin),
    .out_sof  (out_sof),
    .out_en   (out_en),
    .out_fill (out_fill)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       fill;
    logic [6:0] ch;
  } frame_t;

  frame_t     exp_frames[$];
  logic [6:0] m_q[$];
  int         m_bit = 0;
  bit         m_run = 0;
  bit         m_started = 0;
  bit         m_acc = 0;
  logic [6:0] m_cur = 7'h00;
  int         m_pre;
  frame_t     m_f;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      exp_frames.delete();
      m_bit = 0;
      m_run = 0;
      m_started = 0;
      m_acc = 0;
    end else begin
      m_pre = m_q.size();
      m_acc = 0;
      if (m_bit == 0) begin
        if (m_pre > 0) begin
          m_f.ch = m_q.pop_front();
          m_f.fill = 1'b0;
        end else begin
          m_f.ch = 7'h00;
          m_f.fill = 1'b1;
        end
        exp_frames.push_back(m_f);
        m_cur = m_f.ch;
        m_started = 1;
      end
      if (m_run && in_valid && m_pre < 4) begin
        m_q.push_back(in_ascii);
        m_acc = 1;
      end
      m_bit = (m_bit == 6) ? 0 : m_bit + 1;
      m_run = 1;
    end
  end

  // ---------------- serial monitor ----------------
  int         nb = 0;
  logic [6:0] bits;
  logic       fill0;
  logic       fbad;
  bit         saw_not_ready = 0;
  frame_t     got_f;

  always @(negedge clk) begin
    if (!rst) begin
      nb = 0;
      check_eq("rst_out_bin", out_bin, 0);
      check_eq("rst_out_sof", out_sof, 0);
      check_eq("rst_out_en", out_en, 0);
      check_eq("rst_out_fill", out_fill, 0);
      check_eq("rst_in_ready", in_ready, 1);
    end else begin
      if (!in_ready) saw_not_ready = 1;
      check_eq("in_ready", in_ready, (m_q.size() < 4));
      check_eq("out_en", out_en, m_started);
      check_eq("out_sof", out_sof, (m_started && m_bit == 1));
      if (out_sof) begin
        bits = {6'b0, out_bin};
        nb = 1;
        fill0 = out_fill;
        fbad = 1'b0;
      end else if (nb > 0 && nb < 7) begin
        bits = {bits[5:0], out_bin};
        nb++;
        if (out_fill !== fill0) fbad = 1'b1;
      end
      if (nb == 7) begin
        nb = 0;
        check_eq("frame_available", (exp_frames.size() > 0), 1);
        if (exp_frames.size() > 0) begin
          got_f = exp_frames.pop_front();
          check_eq("frame_char", bits, got_f.ch);
          check_eq("frame_fill", fbad ? 2 : fill0, got_f.fill);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_char(input logic [6:0] c);
    int t;
    in_valid = 1'b1;
    in_ascii = c;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m_acc && t < 100);
    check_eq("push_accepted", m_acc, 1);
  endtask

  task automatic wait_bit(input int b);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (m_bit != b && t < 50);
    check_eq("wait_bit", m_bit, b);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [6:0] hello [5] = '{7'h48, 7'h45, 7'h4C, 7'h4C, 7'h4F};
  logic [6:0] t5    [5] = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55};

  initial begin
    #2 rst = 1'b0;
    #1;
    check_eq("init_out_bin", out_bin, 0);
    check_eq("init_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 1: idle stream
    idle(21);

    // 2: single 'A' pushed mid-frame
    wait_bit(3);
    push_char(7'h41);
    idle(21);

    // 3: "HELLO" back-to-back, starting just after a boundary
    wait_bit(1);
    saw_not_ready = 0;
    foreach (hello[i]) push_char(hello[i]);
    in_valid = 1'b0;
    check_eq("t3_backpressure", saw_not_ready, 1);
    idle(50);

    // 4: push on the same edge as an empty-FIFO boundary load
    wait_bit(0);
    in_valid = 1'b1;
    in_ascii = 7'h7F;
    @(negedge clk);
    in_valid = 1'b0;
    idle(21);

    // 5: full FIFO, new char presented across the pop edge
    wait_bit(1);
    saw_not_ready = 0;
    foreach (t5[i]) push_char(t5[i]);
    in_valid = 1'b0;
    check_eq("t5_backpressure", saw_not_ready, 1);
    idle(50);

    // 6: reset at bit 3 of 'Z' with three chars queued
    wait_bit(1);
    push_char(7'h5A);
    in_valid = 1'b0;
    begin
      int t;
      t = 0;
      while (!(m_cur == 7'h5A && m_bit == 1) && t < 30) begin
        @(negedge clk);
        t++;
      end
      check_eq("t6_z_loaded", m_cur, 7'h5A);
    end
    push_char(7'h61);
    push_char(7'h62);
    push_char(7'h63);
    in_valid = 1'b0;
    check_eq("t6_bit_pos", m_bit, 4);
    check_eq("t6_pre_rst_en", out_en, 1);
    #1 rst = 1'b0;
    #1;
    check_eq("t6_async_bin", out_bin, 0);
    check_eq("t6_async_sof", out_sof, 0);
    check_eq("t6_async_en", out_en, 0);
    check_eq("t6_async_fill", out_fill, 0);
    check_eq("t6_async_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(28);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
